// File: rtl/prec_gated_reg_pkg.sv
// Shared types and helpers for the precision-gated pipeline register bank.
// Segment bounds are computed from the word width and segment count so that
// the channel registers and the top-level masks always agree on the layout.
package prec_gated_reg_pkg;

    // Control states: normal operation, waiting for the last word to leave,
    // and the single cycle in which the new precision takes effect.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Lowest bit of segment s; the low segments are all floor(w/nseg) wide.
    function automatic int seg_lo(input int s, input int w, input int nseg);
        return s * (w / nseg);
    endfunction

    // Highest bit of segment s; the top segment absorbs the remainder bits.
    function automatic int seg_hi(input int s, input int w, input int nseg);
        if (s == nseg - 1) begin
            return w - 1;
        end
        return (s + 1) * (w / nseg) - 1;
    endfunction

    // A segment is active when it is among the prec+1 segments at the MSB end.
    function automatic logic seg_active(input int s, input int prec, input int nseg);
        return (s >= (nseg - 1 - prec));
    endfunction

endpackage

// File: rtl/prec_gated_reg_bank_if.sv
// Bus bundle for the precision-gated register bank: input and output
// valid/ready handshakes, precision-change handshake and activity counters.
// The master side is the upstream/controller, the slave side is the bank.
interface prec_gated_reg_bank_if #(
    parameter int W     = 15,
    parameter int NSEG  = 2,
    parameter int CH    = 4,
    parameter int CNT_W = 16,
    parameter int PW    = $clog2(NSEG)
);

    logic                  in_valid;
    logic                  in_ready;
    logic [CH*W-1:0]       din;
    logic                  out_valid;
    logic                  out_ready;
    logic [CH*W-1:0]       dout;
    logic                  prec_req;
    logic [PW-1:0]         prec_i;
    logic                  prec_ack;
    logic [PW-1:0]         prec_q;
    logic [NSEG*CNT_W-1:0] seg_cnt;

    modport master (
        output in_valid,
        output din,
        output out_ready,
        output prec_req,
        output prec_i,
        input  in_ready,
        input  out_valid,
        input  dout,
        input  prec_ack,
        input  prec_q,
        input  seg_cnt
    );

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        input  prec_req,
        input  prec_i,
        output in_ready,
        output out_valid,
        output dout,
        output prec_ack,
        output prec_q,
        output seg_cnt
    );

endinterface

// File: rtl/prec_gated_reg_chan.sv
// One channel word of the bank, stored as independent segment registers.
// Each segment has its own load enable and synchronous clear, which is the
// enable-based stand-in for gating the clock of that segment.
module prec_gated_reg_chan
    import prec_gated_reg_pkg::*;
#(
    parameter int W    = 15,
    parameter int NSEG = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSEG-1:0] seg_load,
    input  logic [NSEG-1:0] seg_clr,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    word
);

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        localparam int LO = seg_lo(s, W, NSEG);
        localparam int HI = seg_hi(s, W, NSEG);

        logic [HI-LO:0] seg_q;

        // Segment register: a load wins over a clear, otherwise the value holds.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                seg_q <= '0;
            end else if (seg_load[s]) begin
                seg_q <= din[HI:LO];
            end else if (seg_clr[s]) begin
                seg_q <= '0;
            end
        end

        assign word[HI:LO] = seg_q;
    end

endmodule

// File: rtl/prec_gated_reg_bank.sv
// Multi-channel precision-scalable pipeline register between the accumulator
// and activation stages. Only the MSB segments selected by the current
// precision update on a load; a drain/clear handshake switches precision at
// run time, and saturating counters record how often each segment updated.
module prec_gated_reg_bank
    import prec_gated_reg_pkg::*;
#(
    parameter int W        = 15,
    parameter int NSEG     = 2,
    parameter int CH       = 4,
    parameter bit ZERO_LSB = 1'b0,
    parameter int CNT_W    = 16,
    parameter int PW       = $clog2(NSEG)
) (
    input logic                   clk,
    input logic                   rst,
    prec_gated_reg_bank_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                state_q;
    state_e                state_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [PW-1:0]         prec_q;
    logic [PW-1:0]         prec_d;
    logic                  in_ready_w;
    logic                  accept;
    logic [NSEG-1:0]       act_mask;
    logic [NSEG-1:0]       new_mask;
    logic [NSEG-1:0]       seg_load;
    logic [NSEG-1:0]       seg_clr;
    logic [CNT_W-1:0]      cnt_q [NSEG];
    logic [NSEG*CNT_W-1:0] seg_cnt_w;
    logic [CH*W-1:0]       dout_w;

    // New words are only taken in RUN, never while a precision change is
    // pending, and only when the output slot is empty or being emptied.
    assign in_ready_w = (state_q == RUN) && !bus.prec_req && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    // Segment masks under the current and the requested precision, and the
    // resulting per-segment load and clear strobes shared by all channels.
    always_comb begin
        act_mask = '0;
        new_mask = '0;
        seg_load = '0;
        seg_clr  = '0;
        for (int s = 0; s < NSEG; s++) begin
            act_mask[s] = seg_active(s, int'(prec_q), NSEG);
            new_mask[s] = seg_active(s, int'(bus.prec_i), NSEG);
            seg_load[s] = accept && act_mask[s];
            seg_clr[s]  = (ZERO_LSB && accept && !act_mask[s])
                        || ((state_q == CLEAR) && !new_mask[s]);
        end
    end

    // Next-state and output-valid logic for the precision-switch handshake.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        prec_d      = prec_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (bus.prec_req) begin
                    if (out_valid_q && !bus.out_ready) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                out_valid_d = 1'b0;
                prec_d      = bus.prec_i;
                state_d     = RUN;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = RUN;
            end
        endcase
    end

    // Control registers; reset comes up at full precision in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            prec_q      <= PW'(NSEG - 1);
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            prec_q      <= prec_d;
        end
    end

    // Per-segment activity counters; they stick at all-ones and only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSEG; s++) begin
                cnt_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSEG; s++) begin
                if (seg_load[s] && (cnt_q[s] != CNT_MAX)) begin
                    cnt_q[s] <= cnt_q[s] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counter array onto the bus, segment s at [s*CNT_W +: CNT_W].
    always_comb begin
        seg_cnt_w = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_cnt_w[s*CNT_W +: CNT_W] = cnt_q[s];
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        prec_gated_reg_chan #(
            .W    (W),
            .NSEG (NSEG)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .seg_load (seg_load),
            .seg_clr  (seg_clr),
            .din      (bus.din[c*W +: W]),
            .word     (dout_w[c*W +: W])
        );
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_w;
    assign bus.prec_ack  = (state_q == CLEAR);
    assign bus.prec_q    = prec_q;
    assign bus.seg_cnt   = seg_cnt_w;

endmodule

// File: tb/tb_prec_gated_reg_bank.sv
// Directed bench for the precision-gated register bank. Two instances share
// the clock and reset: bank A holds inactive segments with 16-bit counters,
// bank B zeroes inactive segments with 4-bit counters to reach saturation.
module tb_prec_gated_reg_bank;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prec_gated_reg_bank_if #(.W(15), .NSEG(2), .CH(2), .CNT_W(16)) bus_a ();
    prec_gated_reg_bank_if #(.W(15), .NSEG(2), .CH(2), .CNT_W(4))  bus_b ();

    prec_gated_reg_bank #(
        .W(15), .NSEG(2), .CH(2), .ZERO_LSB(1'b0), .CNT_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    prec_gated_reg_bank #(
        .W(15), .NSEG(2), .CH(2), .ZERO_LSB(1'b1), .CNT_W(4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.din = '0; bus_a.out_ready = 1'b0; bus_a.prec_req = 1'b0; bus_a.prec_i = '0;
        bus_b.in_valid = 1'b0; bus_b.din = '0; bus_b.out_ready = 1'b0; bus_b.prec_req = 1'b0; bus_b.prec_i = '0;
        #12;
        checks++; if (bus_a.dout !== 30'h0) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=0", bus_a.dout); end
        checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus_a.out_valid); end
        checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_prec_ack got=%b exp=0", bus_a.prec_ack); end
        checks++; if (bus_a.prec_q !== 1'b1) begin failures++; $display("[TB] FAIL reset_prec_q got=%b exp=1", bus_a.prec_q); end
        checks++; if (bus_a.seg_cnt !== 32'h0) begin failures++; $display("[TB] FAIL reset_seg_cnt got=%h exp=0", bus_a.seg_cnt); end
        checks++; if (bus_b.prec_q !== 1'b1) begin failures++; $display("[TB] FAIL reset_b_prec_q got=%b exp=1", bus_b.prec_q); end
        checks++; if (bus_b.seg_cnt !== 8'h0) begin failures++; $display("[TB] FAIL reset_b_seg_cnt got=%h exp=0", bus_b.seg_cnt); end
        rst = 1'b1;
        tick();
        checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus_a.in_ready); end
    endtask

    task automatic test_full_load();
        bus_a.din = {15'h1234, 15'h7FFF};
        bus_a.in_valid = 1'b1;
        bus_a.out_ready = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_in_ready got=%b exp=1", bus_a.in_ready); end
        tick();
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.dout[14:0] !== 15'h7FFF) begin failures++; $display("[TB] FAIL full_ch0 got=%h exp=7fff", bus_a.dout[14:0]); end
        checks++; if (bus_a.dout[29:15] !== 15'h1234) begin failures++; $display("[TB] FAIL full_ch1 got=%h exp=1234", bus_a.dout[29:15]); end
        checks++; if (bus_a.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_out_valid got=%b exp=1", bus_a.out_valid); end
        checks++; if (bus_a.seg_cnt !== 32'h0001_0001) begin failures++; $display("[TB] FAIL full_seg_cnt got=%h exp=00010001", bus_a.seg_cnt); end
        tick();
        checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_consumed got=%b exp=0", bus_a.out_valid); end
    endtask

    task automatic test_prec_down();
        bus_a.prec_i = 1'b0;
        bus_a.prec_req = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL down_in_ready got=%b exp=0", bus_a.in_ready); end
        tick();
        checks++; if (bus_a.prec_ack !== 1'b1) begin failures++; $display("[TB] FAIL down_ack got=%b exp=1", bus_a.prec_ack); end
        checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL down_clear_valid got=%b exp=0", bus_a.out_valid); end
        bus_a.prec_req = 1'b0;
        tick();
        checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL down_ack_pulse got=%b exp=0", bus_a.prec_ack); end
        checks++; if (bus_a.prec_q !== 1'b0) begin failures++; $display("[TB] FAIL down_prec_q got=%b exp=0", bus_a.prec_q); end
        checks++; if (bus_a.dout[14:0] !== 15'h7F80) begin failures++; $display("[TB] FAIL down_clr_ch0 got=%h exp=7f80", bus_a.dout[14:0]); end
        checks++; if (bus_a.dout[29:15] !== 15'h1200) begin failures++; $display("[TB] FAIL down_clr_ch1 got=%h exp=1200", bus_a.dout[29:15]); end
        bus_a.din = {15'h0000, 15'h0055};
        bus_a.in_valid = 1'b1;
        tick();
        checks++; if (bus_a.dout[14:0] !== 15'h0000) begin failures++; $display("[TB] FAIL down_load55 got=%h exp=0000", bus_a.dout[14:0]); end
        bus_a.din = {15'h0000, 15'h4ABC};
        tick();
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.dout[14:0] !== 15'h4A80) begin failures++; $display("[TB] FAIL down_load4abc got=%h exp=4a80", bus_a.dout[14:0]); end
        checks++; if (bus_a.seg_cnt !== 32'h0003_0001) begin failures++; $display("[TB] FAIL down_seg_cnt got=%h exp=00030001", bus_a.seg_cnt); end
    endtask

    task automatic test_backpressure();
        bus_a.out_ready = 1'b0;
        bus_a.prec_i = 1'b1;
        bus_a.prec_req = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready got=%b exp=0", bus_a.in_ready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain_ack[%0d] got=%b exp=0", i, bus_a.prec_ack); end
            checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain_ready[%0d] got=%b exp=0", i, bus_a.in_ready); end
            checks++; if (bus_a.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_drain_valid[%0d] got=%b exp=1", i, bus_a.out_valid); end
            tick();
        end
        bus_a.out_ready = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=0", bus_a.in_ready); end
        tick();
        checks++; if (bus_a.prec_ack !== 1'b1) begin failures++; $display("[TB] FAIL bp_ack got=%b exp=1", bus_a.prec_ack); end
        checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_clear_valid got=%b exp=0", bus_a.out_valid); end
        bus_a.prec_req = 1'b0;
        tick();
        checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL bp_ack_pulse got=%b exp=0", bus_a.prec_ack); end
        checks++; if (bus_a.prec_q !== 1'b1) begin failures++; $display("[TB] FAIL bp_prec_q got=%b exp=1", bus_a.prec_q); end
        checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_run_ready got=%b exp=1", bus_a.in_ready); end
        checks++; if (bus_a.dout[14:0] !== 15'h4A80) begin failures++; $display("[TB] FAIL bp_dout_kept got=%h exp=4a80", bus_a.dout[14:0]); end
    endtask

    task automatic test_prec_up();
        bus_a.din = {15'h5555, 15'h1234};
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.dout[14:0] !== 15'h1234) begin failures++; $display("[TB] FAIL up_ch0 got=%h exp=1234", bus_a.dout[14:0]); end
        checks++; if (bus_a.dout[29:15] !== 15'h5555) begin failures++; $display("[TB] FAIL up_ch1 got=%h exp=5555", bus_a.dout[29:15]); end
        checks++; if (bus_a.seg_cnt !== 32'h0004_0002) begin failures++; $display("[TB] FAIL up_seg_cnt got=%h exp=00040002", bus_a.seg_cnt); end
    endtask

    task automatic test_reset_mid_drain();
        bus_a.out_ready = 1'b0;
        bus_a.prec_i = 1'b0;
        bus_a.prec_req = 1'b1;
        tick();
        tick();
        checks++; if (bus_a.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_drain_valid got=%b exp=1", bus_a.out_valid); end
        checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_drain_ack got=%b exp=0", bus_a.prec_ack); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_a.dout !== 30'h0) begin failures++; $display("[TB] FAIL rd_dout got=%h exp=0", bus_a.dout); end
        checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_out_valid got=%b exp=0", bus_a.out_valid); end
        checks++; if (bus_a.prec_q !== 1'b1) begin failures++; $display("[TB] FAIL rd_prec_q got=%b exp=1", bus_a.prec_q); end
        checks++; if (bus_a.seg_cnt !== 32'h0) begin failures++; $display("[TB] FAIL rd_seg_cnt got=%h exp=0", bus_a.seg_cnt); end
        checks++; if (bus_a.prec_ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_prec_ack got=%b exp=0", bus_a.prec_ack); end
        bus_a.prec_req = 1'b0;
        bus_a.out_ready = 1'b1;
        #2;
        rst = 1'b1;
        tick();
        checks++; if (bus_a.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_after_ready got=%b exp=1", bus_a.in_ready); end
        bus_a.din = {15'h7001, 15'h0ABC};
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        checks++; if (bus_a.dout[14:0] !== 15'h0ABC) begin failures++; $display("[TB] FAIL rd_load_ch0 got=%h exp=0abc", bus_a.dout[14:0]); end
        checks++; if (bus_a.dout[29:15] !== 15'h7001) begin failures++; $display("[TB] FAIL rd_load_ch1 got=%h exp=7001", bus_a.dout[29:15]); end
        checks++; if (bus_a.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_load_valid got=%b exp=1", bus_a.out_valid); end
        checks++; if (bus_a.seg_cnt !== 32'h0001_0001) begin failures++; $display("[TB] FAIL rd_load_cnt got=%h exp=00010001", bus_a.seg_cnt); end
    endtask

    task automatic test_zero_lsb();
        logic [14:0] v0;
        logic [14:0] v1;
        bus_b.out_ready = 1'b1;
        bus_b.prec_i = 1'b0;
        bus_b.prec_req = 1'b1;
        tick();
        checks++; if (bus_b.prec_ack !== 1'b1) begin failures++; $display("[TB] FAIL zl_ack got=%b exp=1", bus_b.prec_ack); end
        bus_b.prec_req = 1'b0;
        tick();
        checks++; if (bus_b.prec_q !== 1'b0) begin failures++; $display("[TB] FAIL zl_prec_q got=%b exp=0", bus_b.prec_q); end
        for (int i = 0; i < 10; i++) begin
            v0 = (i == 0) ? 15'h7FFF : 15'(32'h1357 * (i + 1));
            v1 = ~v0;
            bus_b.din = {v1, v0};
            bus_b.in_valid = 1'b1;
            tick();
            checks++; if (bus_b.dout[14:0] !== (v0 & 15'h7F80)) begin failures++; $display("[TB] FAIL zl_ch0[%0d] got=%h exp=%h", i, bus_b.dout[14:0], v0 & 15'h7F80); end
            checks++; if (bus_b.dout[29:15] !== (v1 & 15'h7F80)) begin failures++; $display("[TB] FAIL zl_ch1[%0d] got=%h exp=%h", i, bus_b.dout[29:15], v1 & 15'h7F80); end
        end
        bus_b.in_valid = 1'b0;
        checks++; if (bus_b.seg_cnt !== 8'hA0) begin failures++; $display("[TB] FAIL zl_seg_cnt got=%h exp=a0", bus_b.seg_cnt); end
    endtask

    task automatic test_saturate();
        logic [14:0] v0;
        logic [14:0] v1;
        int          top_exp;
        int          low_exp;
        bus_b.prec_i = 1'b1;
        bus_b.prec_req = 1'b1;
        tick();
        checks++; if (bus_b.prec_ack !== 1'b1) begin failures++; $display("[TB] FAIL sat_ack got=%b exp=1", bus_b.prec_ack); end
        bus_b.prec_req = 1'b0;
        tick();
        checks++; if (bus_b.prec_q !== 1'b1) begin failures++; $display("[TB] FAIL sat_prec_q got=%b exp=1", bus_b.prec_q); end
        top_exp = 10;
        low_exp = 0;
        for (int i = 0; i < 20; i++) begin
            v0 = 15'(32'h0A5B * (i + 1));
            v1 = 15'(32'h7321 ^ i);
            bus_b.din = {v1, v0};
            bus_b.in_valid = 1'b1;
            #1;
            checks++; if (bus_b.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL sat_ready[%0d] got=%b exp=1", i, bus_b.in_ready); end
            tick();
            top_exp = (top_exp < 15) ? top_exp + 1 : 15;
            low_exp = (low_exp < 15) ? low_exp + 1 : 15;
            checks++; if (bus_b.dout !== {v1, v0}) begin failures++; $display("[TB] FAIL sat_dout[%0d] got=%h exp=%h", i, bus_b.dout, {v1, v0}); end
            checks++; if (bus_b.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL sat_valid[%0d] got=%b exp=1", i, bus_b.out_valid); end
            checks++; if (bus_b.seg_cnt !== {4'(top_exp), 4'(low_exp)}) begin failures++; $display("[TB] FAIL sat_cnt[%0d] got=%h exp=%h", i, bus_b.seg_cnt, {4'(top_exp), 4'(low_exp)}); end
        end
        bus_b.in_valid = 1'b0;
        tick();
        checks++; if (bus_b.seg_cnt !== 8'hFF) begin failures++; $display("[TB] FAIL sat_final got=%h exp=ff", bus_b.seg_cnt); end
    endtask

    // Scenario sequence; bank A first, then bank B after the shared reset pulse.
    initial begin
        test_reset();
        test_full_load();
        test_prec_down();
        test_backpressure();
        test_prec_up();
        test_reset_mid_drain();
        test_zero_lsb();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
